// File: rtl/ws2812_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ws2812_rx_if
//  Description : Bundle of signals between a WS2812 line source and the
//                ws2812_rx decoder. The master drives the serial line and
//                consumes the decoded pixels; the slave is the decoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface ws2812_rx_if #(
    parameter int NUM_LEDS = 4
);
    localparam int AW = $clog2(NUM_LEDS);

    logic          DI;
    logic          pixel_valid;
    logic [AW-1:0] address;
    logic [7:0]    green_out;
    logic [7:0]    red_out;
    logic [7:0]    blue_out;
    logic          frame_done;
    logic          error;
    logic          idle;

    modport master (
        output DI,
        input  pixel_valid, address, green_out, red_out, blue_out,
               frame_done, error, idle
    );

    modport slave (
        input  DI,
        output pixel_valid, address, green_out, red_out, blue_out,
               frame_done, error, idle
    );
endinterface
`default_nettype wire

// File: rtl/ws2812_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ws2812_rx
//  Description : Oversampling decoder for a WS2811/WS2812/SK6812 serial
//                stream. Produces G-R-B pixels with a 0-based LED index,
//                a frame-boundary strobe and a protocol-error strobe.
//                Optional macro WS2812_RX_GLITCH_FILTER_EN inserts a
//                3-sample majority filter after the synchroniser (+2 clk).
//  Revision    : 1.0  initial release
// ============================================================================
module ws2812_rx #(
    parameter int NUM_LEDS      = 4,
    parameter int SYSTEM_CLOCK  = 50_000_000,
    parameter int CYCLE_COUNT   = SYSTEM_CLOCK / 800_000,
    parameter int BIT_THRESHOLD = (CYCLE_COUNT * 3) / 8,
    parameter int RESET_DETECT  = 40 * CYCLE_COUNT,
    parameter int HIGH_TIMEOUT  = 2 * CYCLE_COUNT
) (
    input  wire        clk,
    input  wire        reset,
    ws2812_rx_if.slave bus
);
    localparam int AW  = $clog2(NUM_LEDS);
    localparam int IW  = AW + 1;                     // extra bit flags overflow
    localparam int HCW = $clog2(HIGH_TIMEOUT + 1);
    localparam int LCW = $clog2(RESET_DETECT + 1);

    localparam logic [HCW-1:0] HIGH_ONE  = HCW'(BIT_THRESHOLD);
    localparam logic [HCW-1:0] HIGH_LAST = HCW'(HIGH_TIMEOUT - 1);
    localparam logic [LCW-1:0] LOW_LAST  = LCW'(RESET_DETECT - 1);
    localparam logic [IW-1:0]  IDX_FULL  = IW'(NUM_LEDS);
    localparam logic [4:0]     LAST_BIT  = 5'd23;

    typedef enum logic [1:0] {
        ST_WAIT_RESET = 2'd0,
        ST_IDLE       = 2'd1,
        ST_HIGH       = 2'd2,
        ST_LOW        = 2'd3
    } state_t;

    state_t         state;
    logic           di_meta;
    logic           di_sync;
    logic           ds;
    logic [HCW-1:0] high_cnt;
    logic [LCW-1:0] low_cnt;
    logic [4:0]     bit_cnt;
    logic [IW-1:0]  pix_idx;
    // Only 23 bits are stored: the 24th bit of a pixel goes straight to the
    // output registers in the same cycle it is decoded.
    logic [22:0]    shift_hist;
    logic           bit_is_one;
    logic [23:0]    pixel_word;

    logic           pixel_valid;
    logic [AW-1:0]  address;
    logic [7:0]     green_out;
    logic [7:0]     red_out;
    logic [7:0]     blue_out;
    logic           frame_done;
    logic           error;
    logic           idle;

    // Two-flop synchroniser for the asynchronous data line
    always_ff @(posedge clk) begin
        if (reset) begin
            di_meta <= 1'b0;
            di_sync <= 1'b0;
        end else begin
            di_meta <= bus.DI;
            di_sync <= di_meta;
        end
    end

`ifdef WS2812_RX_GLITCH_FILTER_EN
    logic [1:0] sync_hist;
    logic       ds_filt;

    // Registered 3-sample majority vote removes single-cycle spikes
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_hist <= 2'b00;
            ds_filt   <= 1'b0;
        end else begin
            sync_hist <= {sync_hist[0], di_sync};
            ds_filt   <= (di_sync & sync_hist[0]) | (di_sync & sync_hist[1]) |
                         (sync_hist[0] & sync_hist[1]);
        end
    end

    assign ds = ds_filt;
`else
    assign ds = di_sync;
`endif

    // high_cnt holds the number of high samples seen in the current pulse
    assign bit_is_one = (high_cnt >= HIGH_ONE);
    assign pixel_word = {shift_hist, bit_is_one};

    // Line-state machine: pulse timing, bit assembly, pixel and frame strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_WAIT_RESET;
            high_cnt    <= '0;
            low_cnt     <= '0;
            bit_cnt     <= '0;
            pix_idx     <= '0;
            shift_hist  <= '0;
            pixel_valid <= 1'b0;
            address     <= '0;
            green_out   <= '0;
            red_out     <= '0;
            blue_out    <= '0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
            idle        <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;

            case (state)
                ST_WAIT_RESET: begin
                    if (ds) begin
                        low_cnt <= '0;
                    end else if (low_cnt == LOW_LAST) begin
                        state   <= ST_IDLE;
                        idle    <= 1'b1;
                        low_cnt <= '0;
                        bit_cnt <= '0;
                        pix_idx <= '0;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    bit_cnt <= '0;
                    pix_idx <= '0;
                    if (ds) begin
                        // The rising sample itself is the first high cycle
                        state    <= ST_HIGH;
                        idle     <= 1'b0;
                        high_cnt <= HCW'(1);
                    end
                end

                ST_HIGH: begin
                    if (!ds) begin
                        shift_hist <= pixel_word[22:0];
                        state      <= ST_LOW;
                        low_cnt    <= LCW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (pix_idx < IDX_FULL) begin
                                pixel_valid <= 1'b1;
                                address     <= pix_idx[AW-1:0];
                                green_out   <= pixel_word[23:16];
                                red_out     <= pixel_word[15:8];
                                blue_out    <= pixel_word[7:0];
                                pix_idx     <= pix_idx + 1'b1;
                            end else if (pix_idx == IDX_FULL) begin
                                // First surplus pixel: flag once, then drop silently
                                error   <= 1'b1;
                                pix_idx <= pix_idx + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (high_cnt == HIGH_LAST) begin
                        error   <= 1'b1;
                        state   <= ST_WAIT_RESET;
                        low_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end

                ST_LOW: begin
                    if (ds) begin
                        state    <= ST_HIGH;
                        high_cnt <= HCW'(1);
                    end else if (low_cnt == LOW_LAST) begin
                        // Frame boundary; a pending partial pixel is an error
                        frame_done <= 1'b1;
                        error      <= (bit_cnt != 5'd0);
                        state      <= ST_IDLE;
                        idle       <= 1'b1;
                        bit_cnt    <= '0;
                        pix_idx    <= '0;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                default: state <= ST_WAIT_RESET;
            endcase
        end
    end

    assign bus.pixel_valid = pixel_valid;
    assign bus.address     = address;
    assign bus.green_out   = green_out;
    assign bus.red_out     = red_out;
    assign bus.blue_out    = blue_out;
    assign bus.frame_done  = frame_done;
    assign bus.error       = error;
    assign bus.idle        = idle;

endmodule
`default_nettype wire
